// File: rtl/be_slot_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : be_slot_arbiter
//  Purpose  : Round-robin arbiter sharing one backend transmit engine among
//             NUM_REQ frontend lanes, with per-lane request latching,
//             beat computation and hung-backend timeout recovery.
//  Revision : 1.0  initial release
// ============================================================================
module be_slot_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int LEN_W   = 16,
   parameter int ADDR_W  = 6,
   parameter int TIMEOUT = 4096
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic [NUM_REQ-1:0]           req_start,
   input  logic [NUM_REQ*LEN_W-1:0]     req_length,
   output logic [NUM_REQ-1:0]           req_finish,
   output logic                         be_start,
   output logic [LEN_W-1:0]             be_length,
   output logic [ADDR_W:0]              be_beats,
   output logic [$clog2(NUM_REQ)-1:0]   be_sel,
   input  logic                         be_finish,
   output logic                         busy,
   output logic                         timeout_err,
   output logic                         proto_err
);

   localparam int SEL_W = $clog2(NUM_REQ);
   // Beat arithmetic must hold len+31 without overflow and 2**ADDR_W+1
   localparam int CW    = (LEN_W + 1 > ADDR_W + 2) ? LEN_W + 1 : ADDR_W + 2;
   localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]    TMAX     = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CW-1:0]    BEAT_CAP = CW'(1) << ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_BUSY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 state_q;
   logic [NUM_REQ-1:0]     pending_q, pending_d;
   logic [LEN_W-1:0]       len_q [NUM_REQ];
   logic [SEL_W-1:0]       rr_q;
   logic [SEL_W-1:0]       be_sel_q;
   logic [LEN_W-1:0]       be_length_q;
   logic [ADDR_W:0]        be_beats_q;
   logic                   be_start_q;
   logic                   busy_q;
   logic [NUM_REQ-1:0]     req_finish_q;
   logic                   timeout_err_q;
   logic                   proto_err_q;
   logic [TW-1:0]          timer_q;

   logic                   w_found_hi, w_found_lo, w_gnt_found;
   logic [SEL_W-1:0]       w_idx_hi, w_idx_lo, w_gnt_idx;
   logic [LEN_W-1:0]       w_gnt_len;
   logic [CW-1:0]          w_beats_raw;
   logic                   w_clamp;
   logic [ADDR_W:0]        w_beats;
   logic [SEL_W-1:0]       w_rr_next;
   logic [NUM_REQ-1:0]     w_latch;
   logic                   w_proto_hit;

   // Round-robin pick: lowest pending lane at/above rr wins, else lowest below
   always_comb begin
      w_found_hi = 1'b0;
      w_found_lo = 1'b0;
      w_idx_hi   = '0;
      w_idx_lo   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pending_q[i] && (SEL_W'(i) >= rr_q)) begin
            w_found_hi = 1'b1;
            w_idx_hi   = SEL_W'(i);
         end
         if (pending_q[i] && (SEL_W'(i) < rr_q)) begin
            w_found_lo = 1'b1;
            w_idx_lo   = SEL_W'(i);
         end
      end
      w_gnt_found = w_found_hi | w_found_lo;
      w_gnt_idx   = w_found_hi ? w_idx_hi : w_idx_lo;
      w_gnt_len   = len_q[w_gnt_idx];
      w_beats_raw = (CW'(w_gnt_len) + CW'(31)) >> 5;
      w_clamp     = (w_beats_raw > BEAT_CAP);
      w_beats     = w_clamp ? BEAT_CAP[ADDR_W:0] : w_beats_raw[ADDR_W:0];
      w_rr_next   = (be_sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : be_sel_q + SEL_W'(1);
   end

   // Pending-set bookkeeping and protocol violation detection
   always_comb begin
      pending_d   = pending_q;
      w_latch     = '0;
      w_proto_hit = 1'b0;
      if (state_q == S_IDLE && w_gnt_found) begin
         pending_d[w_gnt_idx] = 1'b0;
         if (w_clamp) w_proto_hit = 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_start[i]) begin
            if (pending_q[i] || (state_q != S_IDLE && be_sel_q == SEL_W'(i))) begin
               w_proto_hit = 1'b1;
            end else begin
               pending_d[i] = 1'b1;
               w_latch[i]   = 1'b1;
            end
         end
      end
   end

   // Pending flags and sticky protocol error
   always_ff @(posedge aclk) begin
      if (areset) begin
         pending_q   <= '0;
         proto_err_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         if (w_proto_hit) proto_err_q <= 1'b1;
      end
   end

   // Per-lane length capture on accepted requests
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < NUM_REQ; i++) len_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_latch[i]) len_q[i] <= req_length[i*LEN_W +: LEN_W];
         end
      end
   end

   // Grant FSM with registered backend and completion outputs
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q       <= S_IDLE;
         rr_q          <= '0;
         be_sel_q      <= '0;
         be_length_q   <= '0;
         be_beats_q    <= '0;
         be_start_q    <= 1'b0;
         busy_q        <= 1'b0;
         req_finish_q  <= '0;
         timeout_err_q <= 1'b0;
         timer_q       <= '0;
      end else begin
         be_start_q    <= 1'b0;
         req_finish_q  <= '0;
         timeout_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (w_gnt_found) begin
                  be_sel_q    <= w_gnt_idx;
                  be_length_q <= w_gnt_len;
                  be_beats_q  <= w_beats;
                  be_start_q  <= (w_gnt_len != '0);
                  busy_q      <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               timer_q <= '0;
               // Zero-length requests complete without touching the backend
               if (be_length_q == '0) begin
                  req_finish_q[be_sel_q] <= 1'b1;
                  state_q                <= S_DONE;
               end else begin
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               timer_q <= timer_q + TW'(1);
               if (be_finish) begin
                  req_finish_q[be_sel_q] <= 1'b1;
                  state_q                <= S_DONE;
               end else if (TIMEOUT != 0 && timer_q == TMAX) begin
                  req_finish_q[be_sel_q] <= 1'b1;
                  timeout_err_q          <= 1'b1;
                  state_q                <= S_DONE;
               end
            end
            S_DONE: begin
               rr_q    <= w_rr_next;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_finish  = req_finish_q;
   assign be_start    = be_start_q;
   assign be_length   = be_length_q;
   assign be_beats    = be_beats_q;
   assign be_sel      = be_sel_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;
   assign proto_err   = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_be_slot_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_be_slot_arbiter
//  Purpose  : Scoreboard bench for be_slot_arbiter with a reactive backend.
//  Revision : 1.0  initial release
// ============================================================================
module tb_be_slot_arbiter;

   localparam int NR = 2;
   localparam int LW = 16;
   localparam int AW = 6;
   localparam int TO = 16;

   logic                  clk = 1'b0;
   logic                  areset;
   logic [NR-1:0]         req_start;
   logic [NR*LW-1:0]      req_length;
   logic [NR-1:0]         req_finish;
   logic                  be_start;
   logic [LW-1:0]         be_length;
   logic [AW:0]           be_beats;
   logic [$clog2(NR)-1:0] be_sel;
   logic                  be_finish;
   logic                  busy;
   logic                  timeout_err;
   logic                  proto_err;
   logic                  bf_drv  = 1'b0;
   logic                  bf_spur = 1'b0;

   assign be_finish = bf_drv | bf_spur;

   always #5 clk = ~clk;

   be_slot_arbiter #(
      .NUM_REQ(NR), .LEN_W(LW), .ADDR_W(AW), .TIMEOUT(TO)
   ) dut (
      .aclk(clk), .areset(areset),
      .req_start(req_start), .req_length(req_length), .req_finish(req_finish),
      .be_start(be_start), .be_length(be_length), .be_beats(be_beats),
      .be_sel(be_sel), .be_finish(be_finish), .busy(busy),
      .timeout_err(timeout_err), .proto_err(proto_err)
   );

   typedef struct { int lane; int len; int beats; } start_t;
   typedef struct { int lane; int len; bit to; bit zero; } fin_t;

   start_t start_q[$];
   fin_t   fin_q[$];
   int     drv_q[$];

   int checks = 0, failures = 0;
   int cyc = 0;
   int m_rr = 0;
   bit exp_proto = 1'b0;
   int last_start_cyc = -100, last_fin_cyc = -100, last_bf_cyc = -100;
   int rlen[NR];
   int rk[NR];
   start_t ms;
   fin_t   mf;
   int     dk;
   int     issue_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Beats as defined: ceil(len/32), capped at the slot depth
   function automatic int exp_beats(input int len);
      int b;
      b = (len + 31) / 32;
      return (b > 2**AW) ? 2**AW : b;
   endfunction

   // Monitor: pops expectations whenever the DUT presents a start or finish
   always @(negedge clk) begin
      if (!areset) begin
         if (be_start) begin
            if (start_q.size() == 0) begin
               chk("unexpected_be_start", 1, 0);
            end else begin
               ms = start_q.pop_front();
               chk("be_sel", be_sel, ms.lane);
               chk("be_length", be_length, ms.len);
               chk("be_beats", be_beats, ms.beats);
               chk("start_gap", (cyc - last_fin_cyc >= 2), 1);
            end
            last_start_cyc = cyc;
         end
         if (req_finish != '0) begin
            if (fin_q.size() == 0) begin
               chk("unexpected_req_finish", req_finish, 0);
            end else begin
               mf = fin_q.pop_front();
               chk("req_finish_lane", req_finish, 1 << mf.lane);
               chk("timeout_err", timeout_err, mf.to);
               chk("busy_at_finish", busy, 1);
               chk("sel_at_finish", be_sel, mf.lane);
               chk("len_at_finish", be_length, mf.len);
               if (!mf.zero) begin
                  if (mf.to) chk("timeout_latency", cyc - last_start_cyc, TO + 1);
                  else       chk("finish_latency", cyc - last_bf_cyc, 1);
               end
            end
            last_fin_cyc = cyc;
         end else if (timeout_err) begin
            chk("stray_timeout_err", 1, 0);
         end
      end
   end

   // Reactive backend: answers the k-th BUSY cycle, or stays silent for k==0
   initial begin
      forever begin
         @(negedge clk);
         if (!areset && be_start && drv_q.size() > 0) begin
            dk = drv_q.pop_front();
            if (dk != 0) begin
               @(posedge clk);
               repeat (dk - 1) @(posedge clk);
               #1 bf_drv = 1'b1;
               last_bf_cyc = cyc;
               @(posedge clk);
               #1 bf_drv = 1'b0;
            end
         end
      end
   end

   // One round: simultaneous requests on mask from an idle arbiter
   task automatic run_round(input logic [NR-1:0] mask, input logic [NR-1:0] dup);
      int lane, last;
      logic [NR*LW-1:0] pk;
      last = m_rr;
      for (int j = 0; j < NR; j++) begin
         lane = (m_rr + j) % NR;
         if (mask[lane]) begin
            if (rlen[lane] != 0) begin
               start_q.push_back('{lane, rlen[lane], exp_beats(rlen[lane])});
               drv_q.push_back(rk[lane]);
               fin_q.push_back('{lane, rlen[lane], (rk[lane] == 0), 1'b0});
            end else begin
               fin_q.push_back('{lane, 0, 1'b0, 1'b1});
            end
            if ((rlen[lane] + 31) / 32 > 2**AW) exp_proto = 1'b1;
            last = lane;
         end
      end
      if (mask != '0) m_rr = (last + 1) % NR;
      if (dup != '0) exp_proto = 1'b1;
      for (int i = 0; i < NR; i++) pk[i*LW +: LW] = LW'(rlen[i]);
      @(posedge clk);
      #1 req_length = pk; req_start = mask; issue_cyc = cyc;
      @(posedge clk);
      #1 req_start = dup; req_length = {NR{16'h5a5a}} ^ LW'($urandom);
      @(posedge clk);
      #1 req_start = '0;
      for (int t = 0; t < 600 && fin_q.size() > 0; t++) @(posedge clk);
      chk("round_drained", fin_q.size(), 0);
      chk("starts_consumed", start_q.size(), 0);
      fin_q.delete(); start_q.delete(); drv_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("proto_err", proto_err, exp_proto);
      chk("idle_after_round", busy, 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req_finish"}, req_finish, 0);
      chk({tag, "_be_start"}, be_start, 0);
      chk({tag, "_be_length"}, be_length, 0);
      chk({tag, "_be_beats"}, be_beats, 0);
      chk({tag, "_be_sel"}, be_sel, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_timeout_err"}, timeout_err, 0);
      chk({tag, "_proto_err"}, proto_err, 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      areset = 1'b1; req_start = '0; req_length = '0;
      repeat (3) @(posedge clk);
      #1 areset = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // Single lane, typical frame
      rlen[0] = 1514; rk[0] = 5; rlen[1] = 0; rk[1] = 1;
      run_round(2'b01, 2'b00);
      chk("start_latency", last_start_cyc - issue_cyc, 2);

      // Both lanes together for ten rounds
      for (int n = 0; n < 10; n++) begin
         rlen[0] = 100 + n; rk[0] = 1 + n % 4;
         rlen[1] = 700 + n; rk[1] = 2 + n % 3;
         run_round(2'b11, 2'b00);
      end

      // Zero-length request on lane 1
      rlen[1] = 0;
      run_round(2'b10, 2'b00);

      // Silent backend times out; answer on the expiry cycle is a normal finish
      rlen[0] = 300; rk[0] = 0;
      run_round(2'b01, 2'b00);
      rlen[0] = 301; rk[0] = TO;
      run_round(2'b01, 2'b00);

      // Spurious backend finish while idle
      @(posedge clk); #1 bf_spur = 1'b1;
      @(posedge clk); #1 bf_spur = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("spurious_busy", busy, 0);
      chk("spurious_proto", proto_err, 0);

      // Largest length that fits the slot exactly, then a duplicate, then overflow
      rlen[0] = 2048; rk[0] = 2;
      run_round(2'b01, 2'b00);
      rlen[0] = 64; rk[0] = 3;
      run_round(2'b01, 2'b01);
      rlen[0] = 4000; rk[0] = 2;
      run_round(2'b01, 2'b00);

      // Reset while busy with lane 1 pending
      start_q.push_back('{0, 100, exp_beats(100)});
      drv_q.push_back(0);
      @(posedge clk);
      #1 req_length = {16'd200, 16'd100}; req_start = 2'b01;
      @(posedge clk);
      #1 req_start = '0;
      repeat (4) @(posedge clk);
      #1 req_start = 2'b10;
      @(posedge clk);
      #1 req_start = '0;
      @(posedge clk);
      #1 areset = 1'b1;
      repeat (2) @(posedge clk);
      #1 areset = 1'b0;
      @(negedge clk);
      check_all_zero("midbusy_reset");
      chk("reset_start_seen", start_q.size(), 0);
      start_q.delete(); fin_q.delete(); drv_q.delete();
      m_rr = 0; exp_proto = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("post_reset_idle", busy, 0);
      rlen[1] = 500; rk[1] = 4;
      run_round(2'b10, 2'b00);

      // Randomized rounds
      for (int n = 0; n < 40; n++) begin
         logic [NR-1:0] mask, dup;
         for (int i = 0; i < NR; i++) begin
            r = $urandom_range(0, 7);
            if (r == 0)      rlen[i] = 0;
            else if (r == 1) rlen[i] = $urandom_range(2049, 65535);
            else             rlen[i] = $urandom_range(1, 2048);
            rk[i] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO);
         end
         mask = NR'($urandom_range(1, 3));
         dup  = ($urandom_range(0, 3) == 0) ? (NR'($urandom_range(0, 3)) & mask) : '0;
         run_round(mask, dup);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
